// File: rtl/vcm_focus_sweep.sv
// Frame-synchronous autofocus sequencer: sweeps the VCM through coarse positions,
// keeps the sharpest one, then parks the lens there.
module vcm_focus_sweep #(
  parameter int unsigned STAT_W        = 18,
  parameter int unsigned STEP_INC      = 16,
  parameter int unsigned STEP_MAX      = 1023,
  parameter int unsigned SETTLE_FRAMES = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic              FRAME_END,
  input  logic [STAT_W-1:0] SHARP,
  input  logic              VCM_ACK,
  output logic              VCM_REQ,
  output logic [15:0]       VCM_DATA,
  output logic [9:0]        STEP,
  output logic [9:0]        BEST_STEP,
  output logic              VCM_END,
  output logic              BUSY
);

  localparam int unsigned POS_W = 10;
  localparam int unsigned SUM_W = POS_W + 1;
  localparam int unsigned CNT_W = 4;

  localparam logic [SUM_W-1:0] INC_X    = SUM_W'(STEP_INC);
  localparam logic [SUM_W-1:0] MAX_X    = SUM_W'(STEP_MAX);
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(STEP_MAX);
  localparam logic [CNT_W-1:0] SETTLE_N = CNT_W'(SETTLE_FRAMES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MOVE,
    S_SETTLE,
    S_MEASURE,
    S_NEXT,
    S_RETURN,
    S_DONE
  } state_t;

  state_t             r_state;
  logic               r_start_d;
  logic [STAT_W-1:0]  r_best_val;
  logic [CNT_W-1:0]   r_frame_cnt;
  logic [POS_W-1:0]   r_step;
  logic [POS_W-1:0]   r_best_step;
  logic               r_req;
  logic [15:0]        r_data;
  logic               r_end;
  logic               r_busy;

  logic               w_start_edge;
  logic [SUM_W-1:0]   w_step_sum;
  logic [POS_W-1:0]   w_step_next;
  logic [CNT_W-1:0]   w_cnt_inc;

  assign w_start_edge = START & ~r_start_d;
  // Next sweep point, computed one bit wider so a large increment cannot wrap past the clamp
  assign w_step_sum   = {1'b0, r_step} + INC_X;
  assign w_step_next  = (w_step_sum > MAX_X) ? LAST_POS : w_step_sum[POS_W-1:0];
  assign w_cnt_inc    = r_frame_cnt + 1'b1;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state     <= S_IDLE;
      r_start_d   <= 1'b0;
      r_best_val  <= '0;
      r_frame_cnt <= '0;
      r_step      <= '0;
      r_best_step <= '0;
      r_req       <= 1'b0;
      r_data      <= '0;
      r_end       <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_start_d <= START;
      case (r_state)
        S_IDLE: begin
          if (w_start_edge) begin
            r_step      <= '0;
            r_data      <= '0;
            r_best_val  <= '0;
            r_best_step <= '0;
            r_end       <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= S_MOVE;
          end
        end
        // Shared handshake: the request rises one cycle after entry, so an early ACK is ignored
        S_MOVE, S_RETURN: begin
          if (r_req && VCM_ACK) begin
            r_req       <= 1'b0;
            r_frame_cnt <= '0;
            r_state     <= (r_state == S_MOVE) ? S_SETTLE : S_DONE;
          end else begin
            r_req <= 1'b1;
          end
        end
        S_SETTLE: begin
          if (SETTLE_N == '0) begin
            r_state <= S_MEASURE;
          end else if (FRAME_END) begin
            r_frame_cnt <= w_cnt_inc;
            if (w_cnt_inc == SETTLE_N) r_state <= S_MEASURE;
          end
        end
        S_MEASURE: begin
          if (FRAME_END) begin
            if (SHARP > r_best_val) begin
              r_best_val  <= SHARP;
              r_best_step <= r_step;
            end
            r_state <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (r_step == LAST_POS) begin
            r_step  <= r_best_step;
            r_data  <= {2'b00, r_best_step, 4'h0};
            r_state <= S_RETURN;
          end else begin
            r_step  <= w_step_next;
            r_data  <= {2'b00, w_step_next, 4'h0};
            r_state <= S_MOVE;
          end
        end
        S_DONE: begin
          r_end   <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign VCM_REQ   = r_req;
  assign VCM_DATA  = r_data;
  assign STEP      = r_step;
  assign BEST_STEP = r_best_step;
  assign VCM_END   = r_end;
  assign BUSY      = r_busy;

endmodule

// File: tb/tb_vcm_focus_sweep.sv
// Bench for vcm_focus_sweep: a lens/I2C/frame environment plus a sweep-level reference model.
module tb_vcm_focus_sweep;

  localparam int STAT_W        = 18;
  localparam int STEP_INC      = 16;
  localparam int STEP_MAX      = 100;
  localparam int SETTLE_FRAMES = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              frame_end;
  logic [STAT_W-1:0] sharp;
  logic              vcm_ack;
  logic              vcm_req;
  logic [15:0]       vcm_data;
  logic [9:0]        step;
  logic [9:0]        best_step;
  logic              vcm_end;
  logic              busy;

  int total = 0;
  int bad   = 0;
  int sharp_tab [1024];
  int ack_lo = 1;
  int ack_hi = 1;

  always #5 clk = ~clk;

  vcm_focus_sweep #(
    .STAT_W       (STAT_W),
    .STEP_INC     (STEP_INC),
    .STEP_MAX     (STEP_MAX),
    .SETTLE_FRAMES(SETTLE_FRAMES)
  ) dut (
    .CLK      (clk),
    .RESET    (rst),
    .START    (start),
    .FRAME_END(frame_end),
    .SHARP    (sharp),
    .VCM_ACK  (vcm_ack),
    .VCM_REQ  (vcm_req),
    .VCM_DATA (vcm_data),
    .STEP     (step),
    .BEST_STEP(best_step),
    .VCM_END  (vcm_end),
    .BUSY     (busy)
  );

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Environment: I2C writer acks after a random delay; the lens reports junk (above any real
  // sharpness) while moving and for SETTLE_FRAMES frames after the ack, then its true value.
  initial begin
    bit waiting;
    bit moving;
    int dly;
    int settle_left;
    int fcnt;
    int lens_pos;
    waiting = 0; moving = 1; dly = 0; settle_left = 0; fcnt = 8; lens_pos = 0;
    vcm_ack = 1'b0; frame_end = 1'b0; sharp = '0;
    forever begin
      @(negedge clk);
      frame_end = 1'b0;
      if (rst) begin
        vcm_ack = 1'b0; waiting = 0; moving = 1;
      end else if (vcm_ack) begin
        vcm_ack = 1'b0; moving = 0; settle_left = SETTLE_FRAMES;
      end else begin
        if (!waiting && vcm_req) begin
          waiting = 1; moving = 1;
          dly = int'($urandom_range(ack_hi, ack_lo));
        end
        if (waiting) begin
          dly--;
          if (dly <= 0) begin
            vcm_ack = 1'b1; waiting = 0; lens_pos = int'(vcm_data[13:4]);
          end
        end
      end
      fcnt--;
      if (fcnt <= 0) begin
        fcnt = int'($urandom_range(12, 6));
        frame_end = 1'b1;
        if (moving || settle_left > 0) begin
          sharp = STAT_W'(262143 - int'($urandom_range(15, 0)));
          if (!moving) settle_left--;
        end else begin
          sharp = STAT_W'(sharp_tab[lens_pos]);
        end
      end else begin
        sharp = STAT_W'($urandom);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},  int'(vcm_req),   0);
    check({tag, "_data"}, int'(vcm_data),  0);
    check({tag, "_step"}, int'(step),      0);
    check({tag, "_best"}, int'(best_step), 0);
    check({tag, "_end"},  int'(vcm_end),   0);
    check({tag, "_busy"}, int'(busy),      0);
  endtask

  // mode 0: plain sweep; 1: extra START edge mid-sweep; 2: reset while in MEASURE of point 2
  task automatic run_sweep(input int mode);
    int pos_q[$];
    int p, n, best_v, best_p, frames, waited, exp_pos;
    logic [15:0] d0;
    p = 0;
    forever begin
      pos_q.push_back(p);
      if (p == STEP_MAX) break;
      p = (p + STEP_INC > STEP_MAX) ? STEP_MAX : p + STEP_INC;
    end
    n = pos_q.size();
    best_v = 0; best_p = 0; frames = 0;

    start = 1'b0; @(posedge clk); #1;
    start = 1'b1; @(posedge clk); #1;
    check("start_busy", int'(busy), 1);
    check("start_req_lat1", int'(vcm_req), 0);
    check("start_end_clr", int'(vcm_end), 0);
    @(posedge clk); #1;
    check("start_req_lat2", int'(vcm_req), 1);

    for (int m = 0; m <= n; m++) begin
      waited = 0;
      while (!vcm_req && waited < 500) begin
        @(posedge clk); #1; waited++;
        if (frame_end) frames++;
      end
      if (!vcm_req) begin
        check("req_timeout", int'(vcm_req), 1);
        return;
      end
      if (m > 0) check("frames_per_point", frames, SETTLE_FRAMES + 1);
      exp_pos = (m < n) ? pos_q[m] : best_p;
      check("move_data", int'(vcm_data), exp_pos << 4);
      check("move_step", int'(step), exp_pos);
      check("best_running", int'(best_step), best_p);

      d0 = vcm_data; waited = 0;
      while (vcm_req && waited < 500) begin
        @(posedge clk); #1; waited++;
        if (vcm_req) begin
          check("req_hold_data", int'(vcm_data), int'(d0));
          check("req_hold_step", int'(step), int'(d0[13:4]));
        end
      end
      if (vcm_req) begin
        check("ack_timeout", int'(vcm_req), 0);
        return;
      end
      check("ack_at_drop", int'(vcm_ack), 1);
      frames = 0;

      if (mode == 1 && m == 2) start = 1'b0;
      if (mode == 1 && m == 3) start = 1'b1;
      if (mode == 2 && m == 2) begin
        waited = 0;
        while (frames < SETTLE_FRAMES && waited < 500) begin
          @(posedge clk); #1; waited++;
          if (frame_end) frames++;
        end
        rst = 1'b1; #1;
        check_reset_outputs("rst_mid");
        repeat (3) @(posedge clk);
        #1; start = 1'b0;
        check("rst_hold_busy", int'(busy), 0);
        rst = 1'b0;
        return;
      end
      if (m < n && sharp_tab[pos_q[m]] > best_v) begin
        best_v = sharp_tab[pos_q[m]];
        best_p = pos_q[m];
      end
    end

    check("done_pend_end", int'(vcm_end), 0);
    check("done_pend_busy", int'(busy), 1);
    @(posedge clk); #1;
    check("done_end", int'(vcm_end), 1);
    check("done_busy", int'(busy), 0);
    check("done_best", int'(best_step), best_p);
    check("done_step", int'(step), best_p);
    check("done_data", int'(vcm_data), best_p << 4);
    check("done_req", int'(vcm_req), 0);
    repeat (5) @(posedge clk);
    #1;
    check("end_holds", int'(vcm_end), 1);
    check("idle_busy", int'(busy), 0);
    check("idle_req", int'(vcm_req), 0);
    start = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_busy", int'(busy), 0);

    // Peak at 48, one-cycle ACK
    ack_lo = 1; ack_hi = 1;
    for (int p = 0; p < 1024; p++) sharp_tab[p] = 250000 - 200 * ((p > 48) ? p - 48 : 48 - p);
    run_sweep(0);
    check("peak_data", int'(vcm_data), 16'h0300);
    check("peak_best", int'(best_step), 48);

    // Tie at 32 and 80: earlier position wins
    ack_lo = 1; ack_hi = 4;
    for (int p = 0; p < 1024; p++) sharp_tab[p] = int'($urandom_range(40000, 0));
    sharp_tab[32] = 50000; sharp_tab[80] = 50000;
    run_sweep(0);
    check("tie_data", int'(vcm_data), 16'h0200);

    // Random profiles with varying ACK latency
    for (int r = 0; r < 3; r++) begin
      ack_lo = 1; ack_hi = 6;
      for (int p = 0; p < 1024; p++) sharp_tab[p] = int'($urandom_range(200000, 0));
      run_sweep(0);
    end

    // Handshake stall of 50 cycles with frames arriving meanwhile
    ack_lo = 50; ack_hi = 50;
    for (int p = 0; p < 1024; p++) sharp_tab[p] = int'($urandom_range(200000, 0));
    run_sweep(0);

    // Second START edge while busy
    ack_lo = 1; ack_hi = 3;
    for (int p = 0; p < 1024; p++) sharp_tab[p] = int'($urandom_range(200000, 0));
    run_sweep(1);

    // Reset in MEASURE, then a clean sweep
    run_sweep(2);
    for (int p = 0; p < 1024; p++) sharp_tab[p] = int'($urandom_range(200000, 0));
    run_sweep(0);

    // Flat zero sharpness never beats the initial best value
    for (int p = 0; p < 1024; p++) sharp_tab[p] = 0;
    run_sweep(0);
    check("zero_best", int'(best_step), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vcm_focus_sweep.md
# vcm_focus_sweep

Frame-synchronous autofocus sequencer for the VCM lens driver. On a start request it steps the VCM through a coarse position sweep and measures a per-frame sharpness statistic at each position. It then drives the lens back to the sharpest position and flags completion. It sits between the pixel high-frequency statistics block (sharpness input), the sync-conditioning logic (frame-end pulse) and the VCM I2C writer (position word plus request/acknowledge).

## Interface
Parameters:
- STAT_W, 18, width of sharpness statistic
- STEP_INC, 16, position increment per sweep point (1..1023)
- STEP_MAX, 1023, last sweep position (0..1023)
- SETTLE_FRAMES, 2, frame-end pulses ignored after each move before measuring (0..15)

Ports:
- CLK, input, 1, single clock; all logic on rising edge
- RESET, input, 1, asynchronous, active-high reset
- START, input, 1, level from focus key (already synchronised); rising edge starts a sweep
- FRAME_END, input, 1, one-cycle pulse per frame, after statistic is final
- SHARP, input, STAT_W, frame sharpness; valid in the cycle FRAME_END is high
- VCM_ACK, input, 1, I2C writer accepted VCM_DATA
- VCM_REQ, output, 1, write request to I2C writer
- VCM_DATA, output, 16, {2'b00, position[9:0], 4'h0}
- STEP, output, 10, current commanded position
- BEST_STEP, output, 10, position of highest sharpness so far
- VCM_END, output, 1, high when lens is parked at best position; low during sweep
- BUSY, output, 1, high in any state other than IDLE

## Operation
- States: IDLE, MOVE, SETTLE, MEASURE, NEXT, RETURN, DONE.
- IDLE: a START rising edge (START high, registered previous value low) resets the internal state: position 0, best value 0, best step 0. Then go to MOVE.
- MOVE: assert VCM_REQ with VCM_DATA from STEP.
  - Hold both stable until VCM_ACK is sampled high.
  - In the ACK cycle go to SETTLE, with the frame counter cleared.
- SETTLE: count FRAME_END pulses. Once SETTLE_FRAMES pulses have been seen, go to MEASURE. With SETTLE_FRAMES=0, go to MEASURE immediately.
- MEASURE: on the next FRAME_END, capture SHARP.
  - If SHARP > best value (strictly greater), update best value and BEST_STEP := STEP.
  - Ties keep the earlier (lower) position.
  - Go to NEXT.
- NEXT:
  - If STEP == STEP_MAX, go to RETURN.
  - Else STEP := min(STEP + STEP_INC, STEP_MAX), computed in 11 bits to avoid wrap, then go to MOVE.
- RETURN: STEP := BEST_STEP, then perform a MOVE-style handshake (VCM_REQ until ACK). On ACK, go to DONE. No settle or measure.
- DONE: VCM_END=1, BUSY=0 the cycle after entry; go to IDLE in the same cycle. VCM_END stays high until the next sweep starts.
- START edges while BUSY are ignored. A start edge is not queued.
- The first position is always 0. Positions swept: 0, INC, 2·INC, …, and STEP_MAX is always the final point.

## Timing
- Reset values: VCM_REQ=0, VCM_DATA=16'h0000, STEP=0, BEST_STEP=0, VCM_END=0, BUSY=0, state IDLE, best value 0.
- RESET asserted mid-sweep returns to reset values at once. No I2C request is pending after reset.
- START edge to VCM_REQ high: 2 cycles (edge register, then MOVE).
- VCM_DATA and STEP are registered. They change only in NEXT or on entry to RETURN, never while VCM_REQ=1.
- VCM_REQ drops the cycle after ACK is sampled. An ACK arriving while REQ=0 is ignored.
- A FRAME_END coincident with the MOVE→SETTLE transition is not counted.
- FRAME_END pulses seen in MOVE or NEXT are ignored.
- Frames per sweep point = SETTLE_FRAMES + 1, plus handshake time.
- The sharpness compare completes within MEASURE. BEST_STEP is visible the cycle after the capturing FRAME_END.

## Test plan
- Basic sweep: STEP_INC=16, STEP_MAX=112, SETTLE_FRAMES=2, ACK one cycle after REQ, sharpness peaks at position 48.
  - Required: 8 points (0…112).
  - VCM_REQ pulses on each move, then a return move with VCM_DATA=16'h0300.
  - BEST_STEP=48, VCM_END=1, BUSY=0.
- Clamp: STEP_INC=16, STEP_MAX=100.
  - Required: positions 0,16,…,96, then 100; no position above 100; exactly 8 measurements.
- Tie: equal maximum SHARP at positions 32 and 80.
  - Required: BEST_STEP=32; final VCM_DATA={2'b00,10'd32,4'h0}=16'h0200.
- Handshake stall: ACK delayed 50 cycles, with FRAME_END pulses during the wait.
  - Required: VCM_REQ and VCM_DATA stable throughout; stalled FRAME_ENDs not counted toward settle.
- START while BUSY: second START edge mid-sweep.
  - Required: sweep unaffected, no restart, no extra measurements.
- Reset mid-operation: assert RESET in MEASURE.
  - Required: all outputs at reset values the same cycle.
  - A new START edge after release gives a clean sweep from position 0.
